// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad emulator and the scanner side:
// FSM states, key-code to row/column mapping and the bounce LFSR step.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAKE  = 2'd1,
        HOLD  = 2'd2,
        BREAK = 2'd3
    } state_t;

    // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1, with bit 7 as the x^8 stage.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [1:0] key_row(input logic [3:0] key);
        return key[3:2];
    endfunction

    function automatic logic [1:0] key_col(input logic [3:0] key);
        return key[1:0];
    endfunction

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/keypad_emulator_tick_gen.sv
// Free-running clock divider. It emits a one-cycle tick every TICK_DIV cycles
// and restarts from zero whenever clear is high.
module tick_gen #(
    parameter int TICK_DIV = 48000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] div_q;
    logic [W-1:0] div_d;

    always_comb begin
        div_d = div_q;
        if (clear || div_q == LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = !clear && (div_q == LAST);

endmodule

// File: rtl/keypad_emulator.sv
// Responder-side 4x4 keypad model: one emulated key press per request, with
// LFSR-driven contact chatter on make/break and a combinational column return.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int         TICK_DIV     = 48000,
    parameter int         BOUNCE_TICKS = 5,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        press_req,
    input  logic [3:0]  key,
    input  logic [15:0] hold_ticks,
    output logic        busy,
    output logic        done,
    output logic        contact,
    input  logic [3:0]  rows,
    output logic [3:0]  cols,
    output state_t      dbg_state
);

    localparam logic [15:0] BOUNCE_LEN = 16'(BOUNCE_TICKS);
    localparam bit          HAS_BOUNCE = (BOUNCE_TICKS != 0);

    state_t      state_q, state_d;
    logic [3:0]  key_q, key_d;
    logic [15:0] hold_q, hold_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        contact_q, contact_d;
    logic        done_q, done_d;

    logic        tick;
    logic [15:0] hold_len;
    logic [15:0] phase_len;
    logic        phase_end;

    // The divider is held cleared in IDLE, so every phase starts on a tick boundary.
    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .clear(state_q == IDLE),
        .tick (tick)
    );

    assign hold_len  = (hold_q == 16'd0) ? 16'd1 : hold_q;
    assign phase_len = (state_q == HOLD) ? hold_len : BOUNCE_LEN;
    assign phase_end = tick && (cnt_q == phase_len - 16'd1);

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        lfsr_d    = lfsr_q;
        done_d    = 1'b0;
        contact_d = 1'b0;

        if (state_q == IDLE) begin
            if (press_req) begin
                key_d   = key;
                hold_d  = hold_ticks;
                cnt_d   = 16'd0;
                state_d = HAS_BOUNCE ? MAKE : HOLD;
            end
        end else if (tick) begin
            if (state_q == MAKE || state_q == BREAK) begin
                lfsr_d = lfsr_step(lfsr_q);
            end
            if (phase_end) begin
                cnt_d = 16'd0;
                case (state_q)
                    MAKE:    state_d = HOLD;
                    HOLD: begin
                        state_d = HAS_BOUNCE ? BREAK : IDLE;
                        done_d  = !HAS_BOUNCE;
                    end
                    default: begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        // Contact is registered against the next state so it lines up with lfsr_q.
        case (state_d)
            MAKE, BREAK: contact_d = lfsr_d[0];
            HOLD:        contact_d = 1'b1;
            default:     contact_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            key_q     <= 4'd0;
            hold_q    <= 16'd0;
            cnt_q     <= 16'd0;
            lfsr_q    <= LFSR_SEED;
            contact_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
            contact_q <= contact_d;
            done_q    <= done_d;
        end
    end

    // Switch-matrix return: only the latched row/column pair can pull a column low.
    always_comb begin
        cols = 4'hF;
        if (contact_q && !rows[key_row(key_q)]) begin
            cols[key_col(key_q)] = 1'b0;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign contact   = contact_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator: a no-bounce instance (a_*) for the column
// mux and press timing, and a bounce instance (b_*) for the LFSR chatter.
module tb_keypad_emulator;
    import keypad_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        press_req_a = 1'b0;
    logic        press_req_b = 1'b0;
    logic [3:0]  key = 4'h0;
    logic [15:0] hold = 16'd0;
    logic [3:0]  rows = 4'hE;

    logic        a_busy, a_done, a_contact;
    logic [3:0]  a_cols;
    state_t      a_state;
    logic        b_busy, b_done, b_contact;
    logic [3:0]  b_cols;
    state_t      b_state;

    int total = 0;
    int bad   = 0;

    keypad_emulator #(.TICK_DIV(4), .BOUNCE_TICKS(0), .LFSR_SEED(8'hA5)) dut_a (
        .clk(clk), .reset(reset), .press_req(press_req_a), .key(key),
        .hold_ticks(hold), .busy(a_busy), .done(a_done), .contact(a_contact),
        .rows(rows), .cols(a_cols), .dbg_state(a_state)
    );

    keypad_emulator #(.TICK_DIV(4), .BOUNCE_TICKS(3), .LFSR_SEED(8'hA5)) dut_b (
        .clk(clk), .reset(reset), .press_req(press_req_b), .key(key),
        .hold_ticks(hold), .busy(b_busy), .done(b_done), .contact(b_contact),
        .rows(rows), .cols(b_cols), .dbg_state(b_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] key;
        logic [3:0] rows;
        logic [3:0] cols;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Returns at the first negedge after the accepting posedge (busy cycle 0).
    task automatic press_a(input logic [3:0] k, input logic [15:0] h);
        @(negedge clk);
        key = k;
        hold = h;
        press_req_a = 1'b1;
        @(negedge clk);
        press_req_a = 1'b0;
    endtask

    task automatic measure_a(input int ncyc, input logic [3:0] exp_cols,
                             output int busy_n, output int done_n,
                             output int done_at, output int cols_n);
        busy_n = 0; done_n = 0; done_at = -1; cols_n = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (i > 0) @(negedge clk);
            busy_n += int'(a_busy);
            cols_n += int'(a_cols == exp_cols);
            if (a_done) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
        end
    endtask

    task automatic wait_done_a(input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (a_done) found = 1'b1;
        end
        check(name, int'(found), 1);
    endtask

    function automatic logic [7:0] model_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    initial begin
        int busy_n, done_n, done_at, cols_n;
        int done1, done2, busy4, busy5;
        logic [7:0] m;
        logic exp_c[36];
        int k;

        vecs[0] = '{key: 4'h6, rows: 4'hD, cols: 4'hB};
        vecs[1] = '{key: 4'h6, rows: 4'hE, cols: 4'hF};
        vecs[2] = '{key: 4'h0, rows: 4'hE, cols: 4'hE};
        vecs[3] = '{key: 4'hF, rows: 4'h7, cols: 4'h7};
        vecs[4] = '{key: 4'hF, rows: 4'h0, cols: 4'h7};
        vecs[5] = '{key: 4'h9, rows: 4'hB, cols: 4'hD};
        vecs[6] = '{key: 4'h9, rows: 4'hF, cols: 4'hF};
        vecs[7] = '{key: 4'h5, rows: 4'h5, cols: 4'hD};
        vecs[8] = '{key: 4'hC, rows: 4'hE, cols: 4'hF};

        // Reset held with row 0 driven low.
        repeat (3) @(negedge clk);
        check("rst_cols", int'(a_cols), 15);
        check("rst_busy", int'(a_busy), 0);
        check("rst_done", int'(a_done), 0);
        check("rst_b_cols", int'(b_cols), 15);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_busy", int'(a_busy), 0);
        check("post_rst_cols", int'(a_cols), 15);
        check("post_rst_contact", int'(a_contact), 0);

        // Clean press: key 6, hold 3 ticks.
        rows = 4'hD;
        press_a(4'h6, 16'd3);
        measure_a(30, 4'hB, busy_n, done_n, done_at, cols_n);
        check("clean_busy_cycles", busy_n, 12);
        check("clean_cols_low_cycles", cols_n, 12);
        check("clean_done_count", done_n, 1);
        check("clean_done_at", done_at, 12);

        // Column mux table, each vector checked mid-HOLD.
        for (int v = 0; v < 9; v++) begin
            rows = 4'hF;
            press_a(vecs[v].key, 16'd2);
            rows = vecs[v].rows;
            #1;
            check($sformatf("col_mux[%0d]", v), int'(a_cols), int'(vecs[v].cols));
            wait_done_a($sformatf("col_mux_done[%0d]", v));
        end

        // Second request with a different key mid-HOLD is ignored.
        rows = 4'hD;
        @(negedge clk);
        key = 4'h6; hold = 16'd3; press_req_a = 1'b1;
        busy_n = 0; done_n = 0; done_at = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            busy_n += int'(a_busy);
            if (a_done) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
            if (i == 0) press_req_a = 1'b0;
            if (i == 5) begin key = 4'hF; press_req_a = 1'b1; end
            if (i == 6) press_req_a = 1'b0;
            if (i == 8) check("ignore_cols_key6", int'(a_cols), 11);
            if (i == 9) begin
                rows = 4'h7; #1;
                check("ignore_cols_not_keyF", int'(a_cols), 15);
                rows = 4'hD;
            end
        end
        check("ignore_busy_cycles", busy_n, 12);
        check("ignore_done_count", done_n, 1);
        check("ignore_done_at", done_at, 12);

        // Back-to-back: press_req held high through the first done.
        @(negedge clk);
        key = 4'h6; hold = 16'd1; press_req_a = 1'b1;
        busy_n = 0; done1 = -1; done2 = -1; busy4 = -1; busy5 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            busy_n += int'(a_busy);
            if (i == 4) busy4 = int'(a_busy);
            if (i == 5) begin busy5 = int'(a_busy); press_req_a = 1'b0; end
            if (a_done) begin
                if (done1 < 0) done1 = i;
                else if (done2 < 0) done2 = i;
            end
        end
        check("b2b_done1_at", done1, 4);
        check("b2b_busy_at_done", busy4, 0);
        check("b2b_restart_busy", busy5, 1);
        check("b2b_done2_at", done2, 9);
        check("b2b_busy_cycles", busy_n, 8);

        // hold_ticks = 0 behaves as one tick.
        press_a(4'h6, 16'd0);
        measure_a(12, 4'hB, busy_n, done_n, done_at, cols_n);
        check("hold0_busy_cycles", busy_n, 4);
        check("hold0_cols_low_cycles", cols_n, 4);
        check("hold0_done_count", done_n, 1);

        // Bounce instance: key 6, hold 3, seed A5.
        m = 8'hA5;
        k = 0;
        for (int t = 0; t < 3; t++) begin
            repeat (4) begin exp_c[k] = m[0]; k++; end
            m = model_step(m);
        end
        repeat (12) begin exp_c[k] = 1'b1; k++; end
        for (int t = 0; t < 3; t++) begin
            repeat (4) begin exp_c[k] = m[0]; k++; end
            m = model_step(m);
        end
        rows = 4'hD;
        @(negedge clk);
        key = 4'h6; hold = 16'd3; press_req_b = 1'b1;
        @(negedge clk);
        press_req_b = 1'b0;
        busy_n = 0; done_n = 0; done_at = -1;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            busy_n += int'(b_busy);
            if (b_done) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
            if (i < 36) begin
                check($sformatf("bounce_contact[%0d]", i), int'(b_contact), int'(exp_c[i]));
                check($sformatf("bounce_cols[%0d]", i), int'(b_cols), exp_c[i] ? 11 : 15);
            end
        end
        check("bounce_busy_cycles", busy_n, 36);
        check("bounce_done_count", done_n, 1);
        check("bounce_done_at", done_at, 36);

        // Reset asserted mid-HOLD: immediate release of the column, no done.
        rows = 4'hD;
        press_a(4'h6, 16'd5);
        repeat (3) @(negedge clk);
        check("midrst_cols_before", int'(a_cols), 11);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_cols", int'(a_cols), 15);
        check("midrst_busy", int'(a_busy), 0);
        check("midrst_contact", int'(a_contact), 0);
        @(negedge clk);
        reset = 1'b1;
        busy_n = 0; done_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            busy_n += int'(a_busy);
            done_n += int'(a_done);
        end
        check("midrst_no_done", done_n, 0);
        check("midrst_stays_idle", busy_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_emulator.md
# keypad_emulator

Responder-side model of the 4x4 matrix keypad. It watches the one-hot active-low row drive from the scanning logic and pulls the matching column low while an emulated key is closed. Each press has a programmable hold time plus bounce intervals generated by an LFSR. The block sits between a stimulus source (test controller or bench) and the keypad-scanner pins. It lets the synchronizer, debounce and read/write path be exercised on hardware or in simulation without a physical keypad.

## Interface
Parameters:
- TICK_DIV, default 48000: clk cycles per tick (1 ms at 48 MHz).
- BOUNCE_TICKS, default 5: ticks of contact chatter on make and on break. A value of 0 disables bounce.
- LFSR_SEED, default 8'hA5: bounce LFSR reset value. Must be nonzero.

Ports:
- clk, input, 1: single system clock.
- reset, input, 1: asynchronous, active-low reset.
- press_req, input, 1: request one press. Sampled only in IDLE.
- key, input, 4: key code. row = key[3:2], col = key[1:0].
- hold_ticks, input, 16: stable-closed duration in ticks. A value of 0 is treated as 1.
- busy, output, 1: a press is in progress.
- done, output, 1: one-cycle pulse when a press completes.
- contact, output, 1: current emulated contact state (1 = closed).
- rows, input, 4: row drive from the scanner. Active-low, normally one-hot.
- cols, output, 4: column return. Idle high (pull-up model). Active-low on closure.

## Operation
- FSM states: IDLE, MAKE, HOLD, BREAK.
- IDLE: contact=0. On press_req=1:
  - Latch key and hold_ticks.
  - Clear the tick divider and tick counter.
  - Go to MAKE, or to HOLD if BOUNCE_TICKS=0.
- MAKE: contact = lfsr[0]. After BOUNCE_TICKS ticks, go to HOLD.
- HOLD: contact=1. After max(hold_ticks,1) ticks, go to BREAK, or to IDLE if BOUNCE_TICKS=0.
- BREAK: contact = lfsr[0]. After BOUNCE_TICKS ticks, go to IDLE and pulse done.
- busy = (state != IDLE).
- press_req while busy is ignored and not queued. key and hold_ticks changes while busy have no effect.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1. Advances once per tick, only in MAKE and BREAK.
- Column rule: cols[c] = 0 iff contact=1, rows[row_l]=0 and c=col_l (latched values). All other cols bits are 1.
- Multiple rows low: only the latched row matters. No ghosting is modelled.
- All-rows-high: cols = 4'hF.
- Reset values: state IDLE, contact=0, busy=0, done=0, cols=4'hF, lfsr=LFSR_SEED, counters 0.

## Timing
- press_req sampled high in IDLE at edge N gives busy=1 after edge N.
- MAKE lasts exactly BOUNCE_TICKS*TICK_DIV cycles. HOLD lasts max(hold_ticks,1)*TICK_DIV cycles. BREAK lasts BOUNCE_TICKS*TICK_DIV cycles.
- done is high for exactly the one cycle after the final tick. busy falls on the same edge.
- A new press_req is accepted in that same cycle (IDLE). Back-to-back presses are allowed.
- contact, busy and done are registered.
- rows to cols is combinational (0 cycles), matching a real switch matrix.
- Reset is async: asserting reset mid-press forces cols=4'hF and busy=0 immediately with no done pulse. Release is synchronous to clk.
- Tick counter and hold counter are 16 bits. No wrap is possible within the 65535-tick hold limit.

## Structure
- Package keypad_pkg holds:
  - enum state_t {IDLE, MAKE, HOLD, BREAK}.
  - Functions key_row(key) and key_col(key).
  - Constant LFSR_TAPS.
- The scanner-side code shares the key-to-row/col mapping from this package.
- Sub-module tick_gen (parameter TICK_DIV, sync clear input, tick pulse output) produces the divider.
- The FSM, LFSR and column mux live in keypad_emulator.

## Test plan
Unless noted: TICK_DIV=4, BOUNCE_TICKS=0.
- Reset: reset=0 with rows=4'hE. Required: cols=4'hF, busy=0, done=0. Release reset. Required: still idle.
- Clean press: key=4'h6 (row1,col2), hold_ticks=3, press_req pulse. Required:
  - With rows=4'hD: cols=4'hB for exactly 12 cycles.
  - With rows=4'hE: cols=4'hF.
  - done pulses once. busy is high 12 cycles.
- Bounce (BOUNCE_TICKS=3, seed A5): contact toggles per the LFSR sequence for 12 cycles in MAKE and 12 in BREAK. Stable HOLD interval in between. Total busy is 36 cycles with hold_ticks=3.
- Ignore while busy: second press_req with key=4'hF mid-HOLD. Required: cols still reflects key 6, single done.
- Back-to-back: press_req held high through done. Required: second press starts the cycle done is asserted.
- hold_ticks=0 and mid-press reset: HOLD lasts 4 cycles. Reset asserted during HOLD: cols=4'hF immediately, no done.
